// File: rtl/jpeg_byte_stuffer_pkg.sv
// Shared types and constants for the JPEG entropy-coded byte stuffer.
// Holds the FSM state encoding, the stuffing/marker bytes and the final-word length clamp.
package jpeg_byte_stuffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EMIT,
    ST_STUFF,
    ST_EOI_HI,
    ST_EOI_LO
  } state_e;

  localparam logic [7:0] STUFF_BYTE    = 8'h00;
  localparam logic [7:0] MARKER_PREFIX = 8'hFF;

  // A final word carries 1..4 valid bytes; 0 and out-of-range values mean a full word.
  function automatic logic [2:0] clamp_last_bytes(input logic [2:0] n);
    return ((n == 3'd0) || (n > 3'd4)) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/jpeg_byte_stuffer_if.sv
// FIFO-drain, byte-stream and end-of-image signals of the byte stuffer.
// master = the stuffer itself; slave = FIFO / downstream / controller side.
interface jpeg_byte_stuffer_if;
  logic        fifo_empty;
  logic        read_req;
  logic [31:0] read_data;
  logic        rdata_valid;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        eoi_req;
  logic [2:0]  eoi_last_bytes;
  logic        eoi_done;
  logic        busy;

  modport master (
    input  fifo_empty, read_data, rdata_valid, out_ready, eoi_req, eoi_last_bytes,
    output read_req, out_byte, out_valid, eoi_done, busy
  );

  modport slave (
    output fifo_empty, read_data, rdata_valid, out_ready, eoi_req, eoi_last_bytes,
    input  read_req, out_byte, out_valid, eoi_done, busy
  );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// Drains 32-bit words from the bitstream FIFO, emits them MSB byte first with 0x00
// stuffed after each 0xFF, and closes the image with the EOI marker after the trimmed last word.
module jpeg_byte_stuffer
  import jpeg_byte_stuffer_pkg::*;
#(
  parameter bit          BYTE_STUFF = 1'b1,
  parameter logic [15:0] EOI_MARKER = 16'hFFD9
) (
  input  logic               clk,
  input  logic               rst,
  jpeg_byte_stuffer_if.master bs
);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  count_q, count_d;
  logic        eoi_pending_q, eoi_pending_d;
  logic [2:0]  last_bytes_q, last_bytes_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_valid_q, out_valid_d;
  logic        eoi_done_q, eoi_done_d;
  logic        accept;
  logic        eoi_take;
  logic        word_is_last;

  assign accept   = out_valid_q && bs.out_ready;
  // A request arriving while one is pending or the marker is going out is dropped.
  assign eoi_take = bs.eoi_req && !eoi_pending_q &&
                    (state_q != ST_EOI_HI) && (state_q != ST_EOI_LO);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    count_d       = count_q;
    eoi_pending_d = eoi_pending_q | eoi_take;
    last_bytes_d  = eoi_take ? clamp_last_bytes(bs.eoi_last_bytes) : last_bytes_q;
    eoi_done_d    = 1'b0;
    bs.read_req   = 1'b0;
    word_is_last  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bs.fifo_empty) begin
          bs.read_req = 1'b1;
          state_d     = ST_WAIT;
        end else if (eoi_pending_q) begin
          state_d = ST_EOI_HI;
        end
      end
      ST_WAIT: begin
        if (bs.rdata_valid) begin
          word_is_last = eoi_pending_d && bs.fifo_empty;
          word_d       = bs.read_data;
          count_d      = word_is_last ? last_bytes_d : 3'd4;
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (accept) begin
          if (BYTE_STUFF && (word_q[31:24] == MARKER_PREFIX)) begin
            state_d = ST_STUFF;
          end else begin
            word_d  = word_q << 8;
            count_d = count_q - 3'd1;
            state_d = (count_q == 3'd1) ? ST_IDLE : ST_EMIT;
          end
        end
      end
      ST_STUFF: begin
        if (accept) begin
          word_d  = word_q << 8;
          count_d = count_q - 3'd1;
          state_d = (count_q == 3'd1) ? ST_IDLE : ST_EMIT;
        end
      end
      ST_EOI_HI: begin
        if (accept) state_d = ST_EOI_LO;
      end
      ST_EOI_LO: begin
        if (accept) begin
          eoi_done_d    = 1'b1;
          eoi_pending_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The stream byte is registered from the next state so out_byte never sees an input path.
    out_valid_d = 1'b1;
    out_byte_d  = out_byte_q;
    unique case (state_d)
      ST_EMIT:   out_byte_d = word_d[31:24];
      ST_STUFF:  out_byte_d = STUFF_BYTE;
      ST_EOI_HI: out_byte_d = EOI_MARKER[15:8];
      ST_EOI_LO: out_byte_d = EOI_MARKER[7:0];
      default:   out_valid_d = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_q        <= '0;
      count_q       <= '0;
      eoi_pending_q <= 1'b0;
      last_bytes_q  <= '0;
      out_byte_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      eoi_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      count_q       <= count_d;
      eoi_pending_q <= eoi_pending_d;
      last_bytes_q  <= last_bytes_d;
      out_byte_q    <= out_byte_d;
      out_valid_q   <= out_valid_d;
      eoi_done_q    <= eoi_done_d;
    end
  end

  assign bs.out_byte  = out_byte_q;
  assign bs.out_valid = out_valid_q;
  assign bs.eoi_done  = eoi_done_q;
  assign bs.busy      = (state_q != ST_IDLE) || eoi_pending_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench: lane 0 stuffs (BYTE_STUFF=1), lane 1 passes through (BYTE_STUFF=0).
// Each lane drains a small FIFO model; a monitor scores every accepted byte against a queue.
module tb_jpeg_byte_stuffer;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } sb_t;

  logic clk;
  logic rst;

  logic [31:0] mem [2][16];
  logic [3:0]  wr_ptr [2];
  sb_t         exp_q [2][$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_stall [2];
  logic [7:0] prev_byte [2];
  logic done_next;

  jpeg_byte_stuffer_if bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [3:0] rd_ptr = '0;

    jpeg_byte_stuffer #(.BYTE_STUFF(g == 0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bs  (bus[g])
    );

    assign bus[g].fifo_empty = (rd_ptr == wr_ptr[g]);

    // FIFO model: a pop accepted at an edge returns its word with rdata_valid one cycle later.
    always @(posedge clk) begin
      if (bus[g].read_req && !bus[g].fifo_empty) begin
        bus[g].read_data   <= mem[g][rd_ptr];
        bus[g].rdata_valid <= 1'b1;
        rd_ptr             <= rd_ptr + 4'd1;
      end else begin
        bus[g].rdata_valid <= 1'b0;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [31:0] w);
    mem[i][wr_ptr[i]] = w;
    wr_ptr[i] = wr_ptr[i] + 4'd1;
  endtask

  task automatic expect_byte(input int i, input logic [7:0] b, input logic last = 1'b0);
    exp_q[i].push_back('{b: b, last: last});
  endtask

  task automatic mon_byte(input int i, input logic v, input logic r, input logic [7:0] b);
    sb_t e;
    if (prev_stall[i]) begin
      check($sformatf("hold_valid%0d", i), {31'd0, v}, 32'd1);
      check($sformatf("hold_byte%0d", i), {24'd0, b}, {24'd0, prev_byte[i]});
    end
    if (v === 1'b1 && r === 1'b1 && rst === 1'b0) begin
      check($sformatf("byte_expected%0d", i), {31'd0, exp_q[i].size() != 0}, 32'd1);
      if (exp_q[i].size() != 0) begin
        e = exp_q[i].pop_front();
        check($sformatf("out_byte%0d", i), {24'd0, b}, {24'd0, e.b});
        if (i == 0) done_next = e.last;
      end
    end
    prev_stall[i] = (v === 1'b1) && (r !== 1'b1) && (rst === 1'b0);
    prev_byte[i]  = b;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                bus[0].busy !== 1'b0 || bus[1].busy !== 1'b0) && n < budget);
    check({tag, "_drain"}, {31'd0, n < budget}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic rr_seen;
    int   n;

    rst = 1'b1;
    wr_ptr[0] = '0;
    wr_ptr[1] = '0;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    prev_byte[0] = '0;
    prev_byte[1] = '0;
    done_next = 1'b0;
    bus[0].out_ready = 1'b1;
    bus[1].out_ready = 1'b1;
    bus[0].eoi_req = 1'b0;
    bus[1].eoi_req = 1'b0;
    bus[0].eoi_last_bytes = 3'd0;
    bus[1].eoi_last_bytes = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'd0, bus[0].out_valid}, 32'd0);
    check("rst_out_byte",  {24'd0, bus[0].out_byte}, 32'h00);
    check("rst_busy",      {31'd0, bus[0].busy}, 32'd0);
    check("rst_read_req",  {31'd0, bus[0].read_req}, 32'd0);
    check("rst_eoi_done",  {31'd0, bus[0].eoi_done}, 32'd0);

    fork
      forever begin
        @(negedge clk);
        check("eoi_done", {31'd0, bus[0].eoi_done}, {31'd0, done_next});
        done_next = 1'b0;
        mon_byte(0, bus[0].out_valid, bus[0].out_ready, bus[0].out_byte);
        mon_byte(1, bus[1].out_valid, bus[1].out_ready, bus[1].out_byte);
      end
    join_none

    // 1: plain word, pop -> capture -> first valid byte two cycles later
    @(posedge clk); #1;
    push_word(0, 32'h12345678);
    expect_byte(0, 8'h12); expect_byte(0, 8'h34); expect_byte(0, 8'h56); expect_byte(0, 8'h78);
    @(negedge clk);
    check("lat_read_req", {31'd0, bus[0].read_req}, 32'd1);
    check("lat_valid_t0", {31'd0, bus[0].out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid_t1", {31'd0, bus[0].out_valid}, 32'd0);
    check("lat_rr_wait",  {31'd0, bus[0].read_req}, 32'd0);
    @(negedge clk);
    check("lat_valid_t2", {31'd0, bus[0].out_valid}, 32'd1);
    wait_drain("t1", 40);

    // 2: 0xFF bytes stuffed on lane 0, passed through on lane 1
    push_word(0, 32'hFF00FFAB);
    push_word(1, 32'hFF00FFAB);
    expect_byte(0, 8'hFF); expect_byte(0, 8'h00); expect_byte(0, 8'h00);
    expect_byte(0, 8'hFF); expect_byte(0, 8'h00); expect_byte(0, 8'hAB);
    expect_byte(1, 8'hFF); expect_byte(1, 8'h00); expect_byte(1, 8'hFF); expect_byte(1, 8'hAB);
    wait_drain("t2", 40);

    // 3: downstream stalls every other cycle; monitor checks the held byte
    push_word(0, 32'hA1B2C3D4);
    expect_byte(0, 8'hA1); expect_byte(0, 8'hB2); expect_byte(0, 8'hC3); expect_byte(0, 8'hD4);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus[0].out_ready = ~bus[0].out_ready;
    end
    bus[0].out_ready = 1'b1;
    wait_drain("t3", 40);

    // 4: two words then EOI with 3 valid bytes in the final word
    push_word(0, 32'h11223344);
    push_word(0, 32'h5566FF77);
    expect_byte(0, 8'h11); expect_byte(0, 8'h22); expect_byte(0, 8'h33); expect_byte(0, 8'h44);
    expect_byte(0, 8'h55); expect_byte(0, 8'h66); expect_byte(0, 8'hFF); expect_byte(0, 8'h00);
    expect_byte(0, 8'hFF); expect_byte(0, 8'hD9, 1'b1);
    @(posedge clk); #1;
    bus[0].eoi_req = 1'b1;
    bus[0].eoi_last_bytes = 3'd3;
    @(posedge clk); #1;
    bus[0].eoi_req = 1'b0;
    bus[0].eoi_last_bytes = 3'd0;
    wait_drain("t4", 60);

    // 5: EOI on an empty FIFO, length 0 -> marker only, no pop
    expect_byte(0, 8'hFF); expect_byte(0, 8'hD9, 1'b1);
    bus[0].eoi_req = 1'b1;
    bus[0].eoi_last_bytes = 3'd0;
    rr_seen = bus[0].read_req;
    @(posedge clk); #1;
    bus[0].eoi_req = 1'b0;
    n = 0;
    while ((exp_q[0].size() != 0 || bus[0].busy !== 1'b0) && n < 30) begin
      rr_seen = rr_seen | bus[0].read_req;
      @(posedge clk); #1;
      n++;
    end
    check("t5_no_read_req", {31'd0, rr_seen}, 32'd0);
    wait_drain("t5", 10);

    // 7: EOI raised in the capture cycle of a lone word, length 6 clamps to 4
    push_word(0, 32'hCAFEBABE);
    expect_byte(0, 8'hCA); expect_byte(0, 8'hFE); expect_byte(0, 8'hBA); expect_byte(0, 8'hBE);
    expect_byte(0, 8'hFF); expect_byte(0, 8'hD9, 1'b1);
    @(posedge clk); #1;
    bus[0].eoi_req = 1'b1;
    bus[0].eoi_last_bytes = 3'd6;
    @(posedge clk); #1;
    bus[0].eoi_req = 1'b0;
    bus[0].eoi_last_bytes = 3'd0;
    wait_drain("t7", 40);

    // 6: reset after two bytes of a word discards the remainder
    push_word(0, 32'hDEADBEEF);
    expect_byte(0, 8'hDE); expect_byte(0, 8'hAD);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q[0].size() != 0 && n < 30);
    check("t6_two_bytes", {31'd0, n < 30}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", {31'd0, bus[0].out_valid}, 32'd0);
    check("t6_busy",      {31'd0, bus[0].busy}, 32'd0);
    check("t6_read_req",  {31'd0, bus[0].read_req}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_more_bytes", {31'd0, bus[0].out_valid}, 32'd0);
    wait_drain("t6", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
